mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised memory sequencer between the CPU datapath and the byte-wide SRAM. It accepts one 8- or 16-bit read/write request per handshake and splits 16-bit transfers into two little-endian byte cycles. Each byte cycle is stretched by a configurable number of wait states. It replaces direct SRAM strobing so that slower memories and PC/SP-width transfers need no extra controlpath microcycles.

## Interface
- `ADDR_W`, 16, address width in bits.
- `DATA_W`, 8, memory byte width in bits; wide transfers are 2*`DATA_W`.
- `WAIT_STATES`, 0, extra cycles each byte cycle holds its strobe (0..15).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request (IDLE only).
- `req_write`  in  1  1 = write, 0 = read.
- `req_wide`  in  1  1 = 2-byte transfer, 0 = 1 byte.
- `req_addr`  in  `ADDR_W`  base address (low byte address).
- `req_wdata`  in  2*`DATA_W`  write data; low byte at `req_addr`.
- `resp_valid`  out  1  one-cycle completion pulse (reads and writes).
- `resp_rdata`  out  2*`DATA_W`  read data, valid with and held after `resp_valid`.
- `mem_addr`  out  `ADDR_W`  SRAM address.
- `mem_wdata`  out  `DATA_W`  SRAM write byte.
- `mem_rdata`  in  `DATA_W`  SRAM read byte.
- `mem_re`  out  1  SRAM read strobe.
- `mem_we`  out  1  SRAM write strobe.

## Operation
- FSM states: IDLE, BYTE_LO, BYTE_HI, RESP.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready` the unit latches `req_write`, `req_wide`, `req_addr` and `req_wdata`, then moves to BYTE_LO.
- BYTE_LO: `mem_addr`=addr, `mem_wdata`=wdata[`DATA_W`-1:0], strobe = `mem_re` or `mem_we` per the latched write bit. It stays WAIT_STATES+1 cycles. On the last cycle a read captures `mem_rdata` into the low byte. Next state is BYTE_HI if wide, else RESP.
- BYTE_HI: same as BYTE_LO with `mem_addr`=addr+1 (modulo 2^`ADDR_W`) and the high byte. Next state is RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. `req_ready`=0.
- Narrow read: `resp_rdata` high byte = 0. Write: `resp_rdata` unchanged.
- `mem_re` and `mem_we` are never both 1. Both are 0 in IDLE and RESP.
- Requests presented while `req_ready`=0 are ignored; the requester holds them.
- The unit applies no backpressure on the response; there is no response queue.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `mem_re`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0. All memory outputs are registered.
- Let W=WAIT_STATES and accept edge = cycle 0:
  - Narrow: strobe cycles 1..W+1; `resp_valid` at cycle W+2; `req_ready` high again at cycle W+3.
  - Wide: low byte cycles 1..W+1, high byte cycles W+2..2W+2; `resp_valid` at cycle 2W+3.
- The strobe stays high continuously across BYTE_LO→BYTE_HI; only the address and data change.
- Wrap: a wide access at addr = 2^`ADDR_W`-1 uses address 0 for the high byte.
- Reset mid-transfer: immediate return to reset values, strobes drop asynchronously, no `resp_valid`. A partial wide write leaves only the low byte written.
- The wait counter reloads to W on every byte-cycle entry. W=0 gives one cycle per byte.

## Structure
- `mau_state_t` (IDLE, BYTE_LO, BYTE_HI, RESP) goes in `constants.sv`, alongside the existing control typedefs.
- One sub-module, `wait_timer`: a loadable down-counter with a `done` output, sized $clog2(WAIT_STATES+1) (minimum 1 bit).
- Datapath integration: the datapath drives `req_*` in place of the direct SRAM strobes. The controlpath stalls on `resp_valid`.

## Test plan
- Reset with `rst_n`=0 mid-wide-write at W=2 → all strobes drop the same cycle, `req_ready`=1 after release, no `resp_valid`, only the low byte is written in SRAM.
- W=0 narrow read at 0x1234 where mem[0x1234]=0xAB → `mem_re` high for 1 cycle, `resp_valid` at cycle 2, `resp_rdata`=0x00AB.
- W=3 wide write of 0xBEEF at 0xC000 → `mem_we` high for 8 cycles; 0xEF at 0xC000, 0xBE at 0xC001; `resp_valid` at cycle 9.
- Wide read at 0xFFFF where mem[0xFFFF]=0x34 and mem[0x0000]=0x12 → `resp_rdata`=0x1234; the high-byte address is 0x0000.
- Back-to-back: `req_valid` held high across two narrow reads at W=1 → second accept occurs exactly at cycle 4; `req_ready`=0 during cycles 1..3.
- Random req/wait mix against an SRAM model → `mem_re`&&`mem_we` never both 1; every accepted request yields exactly one `resp_valid`.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types and helpers for the memory access unit
package mem_access_unit_pkg;

    // Sequencer states: one byte cycle per half of a wide transfer, then a response slot.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BYTE_LO = 2'd1,
        BYTE_HI = 2'd2,
        RESP    = 2'd3
    } mau_state_t;

    // Width of a down-counter that must hold values 0..wait_states (never below 1 bit).
    function automatic int timer_width(input int wait_states);
        return (wait_states > 0) ? $clog2(wait_states + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_access_unit_wait_timer.sv
// rtl/mem_access_unit_wait_timer.sv - loadable down-counter pacing each byte cycle
module wait_timer
    import mem_access_unit_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic done_o
);

    localparam int CNT_W = timer_width(WAIT_STATES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on byte-cycle entry, otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(WAIT_STATES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Zero means the current cycle is the last one of the byte cycle.
    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte-wide SRAM sequencer for 8/16-bit read/write requests
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_wide,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                resp_valid,
    output logic [2*DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_re,
    output logic                mem_we
);

    mau_state_t state_q;
    mau_state_t state_d;

    logic                accept;
    logic                tmr_load;
    logic                tmr_done;

    logic                write_q;
    logic                wide_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [2*DATA_W-1:0] wdata_q;

    logic                cur_write;
    logic [ADDR_W-1:0]   cur_addr;
    logic [2*DATA_W-1:0] cur_wdata;

    logic [2*DATA_W-1:0] rdata_q;
    logic [2*DATA_W-1:0] rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic                mem_re_q;
    logic                mem_re_d;
    logic                mem_we_q;
    logic                mem_we_d;

    assign accept = req_valid && (state_q == IDLE);

    // The accepting edge must already drive the first strobe, so the registered
    // memory outputs see the incoming request directly rather than the latched copy.
    assign cur_write = accept ? req_write : write_q;
    assign cur_addr  = accept ? req_addr  : addr_q;
    assign cur_wdata = accept ? req_wdata : wdata_q;

    // Every entry into a byte cycle restarts the wait count.
    assign tmr_load = ((state_d == BYTE_LO) || (state_d == BYTE_HI)) && (state_d != state_q);

    wait_timer #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load),
        .done_o (tmr_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: byte cycles advance only on the last wait cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = BYTE_LO;
            BYTE_LO: if (tmr_done)  state_d = wide_q ? BYTE_HI : RESP;
            BYTE_HI: if (tmr_done)  state_d = RESP;
            RESP:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered SRAM pins and read-data capture.
    always_comb begin
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;

        unique case (state_d)
            BYTE_LO: begin
                mem_re_d    = !cur_write;
                mem_we_d    = cur_write;
                mem_addr_d  = cur_addr;
                mem_wdata_d = cur_wdata[DATA_W-1:0];
            end
            BYTE_HI: begin
                mem_re_d    = !cur_write;
                mem_we_d    = cur_write;
                mem_addr_d  = cur_addr + ADDR_W'(1);
                mem_wdata_d = cur_wdata[2*DATA_W-1:DATA_W];
            end
            default: begin
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase

        // Reads sample the SRAM on the final cycle of each byte cycle; a narrow
        // read clears the high byte at the same moment so the result is whole.
        if (!write_q && tmr_done) begin
            if (state_q == BYTE_LO) begin
                rdata_d[DATA_W-1:0] = mem_rdata;
                if (!wide_q) begin
                    rdata_d[2*DATA_W-1:DATA_W] = '0;
                end
            end else if (state_q == BYTE_HI) begin
                rdata_d[2*DATA_W-1:DATA_W] = mem_rdata;
            end
        end
    end

    // Request latch, loaded only on the accepting handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            wide_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= req_write;
            wide_q  <= req_wide;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Registered SRAM pins and response data; reset drops the strobes at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit at wait states 0..3
module tb_mem_access_unit;

    typedef struct packed {
        logic [1:0]  k;
        logic [15:0] d;
    } exp_t;

    logic        clk;
    logic        rst_n      [4];
    logic        req_valid  [4];
    logic        req_ready  [4];
    logic        req_write  [4];
    logic        req_wide   [4];
    logic [15:0] req_addr   [4];
    logic [15:0] req_wdata  [4];
    logic        resp_valid [4];
    logic [15:0] resp_rdata [4];
    logic [15:0] mem_addr   [4];
    logic [7:0]  mem_wdata  [4];
    logic [7:0]  mem_rdata  [4];
    logic        mem_re     [4];
    logic        mem_we     [4];

    logic [7:0]  mem    [4][65536];
    logic [7:0]  shadow [4][65536];
    logic        bd_we  [4];
    logic [15:0] bd_addr;
    logic [7:0]  bd_data;

    exp_t        exp_q [$];
    logic [15:0] last_rd  [4];
    int          acc      [4];
    int          resp_cnt [4];
    int          n_checks;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_dut
        mem_access_unit #(
            .ADDR_W      (16),
            .DATA_W      (8),
            .WAIT_STATES (i)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[i]),
            .req_valid  (req_valid[i]),
            .req_ready  (req_ready[i]),
            .req_write  (req_write[i]),
            .req_wide   (req_wide[i]),
            .req_addr   (req_addr[i]),
            .req_wdata  (req_wdata[i]),
            .resp_valid (resp_valid[i]),
            .resp_rdata (resp_rdata[i]),
            .mem_addr   (mem_addr[i]),
            .mem_wdata  (mem_wdata[i]),
            .mem_rdata  (mem_rdata[i]),
            .mem_re     (mem_re[i]),
            .mem_we     (mem_we[i])
        );
    end

    // Asynchronous-read SRAM models, one per instance.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_rdata[i] = mem[i][mem_addr[i]];
        end
    end

    // SRAM writes from the DUT strobes and from the bench preload port.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we[i]) mem[i][mem_addr[i]] <= mem_wdata[i];
            if (bd_we[i])  mem[i][bd_addr]     <= bd_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: strobe exclusivity every cycle, scoreboard pop on each response.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("excl[%0d]", i), 32'(mem_re[i] && mem_we[i]), 32'd0);
            if (resp_valid[i]) begin
                resp_cnt[i]++;
                if (exp_q.size() == 0) begin
                    chk($sformatf("unexpected_resp[%0d]", i), 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("resp_inst[%0d]", i), 32'(e.k), 32'(i));
                    chk($sformatf("resp_rdata[%0d]", i), 32'(resp_rdata[i]), 32'(e.d));
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic backdoor(input int k, input logic [15:0] a, input logic [7:0] d);
        bd_we[k]     = 1'b1;
        bd_addr      = a;
        bd_data      = d;
        shadow[k][a] = d;
        sync();
        bd_we[k] = 1'b0;
    endtask

    // Presents a request and returns just after the accepting edge (cycle 0).
    task automatic issue(input int k, input bit wr, input bit wide, input logic [15:0] a,
                         input logic [15:0] wd, input bit track, output int waited);
        bit          ok;
        logic [15:0] a_hi;
        exp_t        e;
        a_hi         = a + 16'd1;
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_wide[k]  = wide;
        req_addr[k]  = a;
        req_wdata[k] = wd;
        ok           = 1'b0;
        waited       = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[k]) ok = 1'b1;
            else waited++;
            sync();
        end
        req_valid[k] = 1'b0;
        chk($sformatf("accept[%0d]", k), 32'(ok), 32'd1);
        if (ok && track) begin
            acc[k]++;
            if (wr) begin
                shadow[k][a] = wd[7:0];
                if (wide) shadow[k][a_hi] = wd[15:8];
            end else begin
                last_rd[k] = wide ? {shadow[k][a_hi], shadow[k][a]} : {8'h00, shadow[k][a]};
            end
            e.k = 2'(k);
            e.d = last_rd[k];
            exp_q.push_back(e);
        end
    endtask

    // Checks every pin cycle by cycle after an accept, using the documented timing.
    task automatic check_trace(input int k, input int w, input bit wr, input bit wide,
                               input logic [15:0] a, input logic [15:0] wd);
        int          s;
        logic [15:0] a_hi;
        bit          strobe;
        bit          hi;
        s    = wide ? 2 * (w + 1) : (w + 1);
        a_hi = a + 16'd1;
        for (int c = 1; c <= s + 3; c++) begin
            @(negedge clk);
            strobe = (c <= s);
            hi     = (c > w + 1);
            chk($sformatf("re[%0d]c%0d", k, c), 32'(mem_re[k]), 32'(strobe && !wr));
            chk($sformatf("we[%0d]c%0d", k, c), 32'(mem_we[k]), 32'(strobe && wr));
            if (strobe) begin
                chk($sformatf("addr[%0d]c%0d", k, c), 32'(mem_addr[k]), 32'(hi ? a_hi : a));
                if (wr) chk($sformatf("wdata[%0d]c%0d", k, c), 32'(mem_wdata[k]),
                            32'(hi ? wd[15:8] : wd[7:0]));
            end
            chk($sformatf("resp_valid[%0d]c%0d", k, c), 32'(resp_valid[k]), 32'(c == s + 1));
            chk($sformatf("req_ready[%0d]c%0d", k, c), 32'(req_ready[k]), 32'(c >= s + 2));
        end
    endtask

    initial begin
        int          waited;
        int          k;
        bit          wr;
        bit          wide;
        logic [15:0] a;
        logic [15:0] wd;

        n_checks = 0;
        n_fail   = 0;
        bd_addr  = '0;
        bd_data  = '0;
        for (int i = 0; i < 4; i++) begin
            rst_n[i]     = 1'b0;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_wide[i]  = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            bd_we[i]     = 1'b0;
            last_rd[i]   = '0;
            acc[i]       = 0;
            resp_cnt[i]  = 0;
        end

        // Reset values on every instance.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_ready[%0d]", i), 32'(req_ready[i]), 32'd1);
            chk($sformatf("rst_resp_valid[%0d]", i), 32'(resp_valid[i]), 32'd0);
            chk($sformatf("rst_rdata[%0d]", i), 32'(resp_rdata[i]), 32'd0);
            chk($sformatf("rst_re[%0d]", i), 32'(mem_re[i]), 32'd0);
            chk($sformatf("rst_we[%0d]", i), 32'(mem_we[i]), 32'd0);
            chk($sformatf("rst_addr[%0d]", i), 32'(mem_addr[i]), 32'd0);
            chk($sformatf("rst_wdata[%0d]", i), 32'(mem_wdata[i]), 32'd0);
            rst_n[i] = 1'b1;
        end
        sync();

        // W=0 narrow read at 0x1234 holding 0xAB.
        backdoor(0, 16'h1234, 8'hAB);
        issue(0, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1, waited);
        check_trace(0, 0, 1'b0, 1'b0, 16'h1234, 16'h0000);
        chk("narrow_rd_value", 32'(resp_rdata[0]), 32'h00AB);
        sync();

        // W=3 wide write of 0xBEEF at 0xC000.
        issue(3, 1'b1, 1'b1, 16'hC000, 16'hBEEF, 1'b1, waited);
        check_trace(3, 3, 1'b1, 1'b1, 16'hC000, 16'hBEEF);
        chk("wide_wr_lo", 32'(mem[3][16'hC000]), 32'hEF);
        chk("wide_wr_hi", 32'(mem[3][16'hC001]), 32'hBE);
        sync();

        // Wide read wrapping from 0xFFFF to 0x0000 (W=1).
        backdoor(1, 16'hFFFF, 8'h34);
        backdoor(1, 16'h0000, 8'h12);
        issue(1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, waited);
        check_trace(1, 1, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
        chk("wrap_rd_value", 32'(resp_rdata[1]), 32'h1234);
        sync();

        // Back-to-back narrow reads at W=1 with req_valid held.
        backdoor(1, 16'h2000, 8'h5A);
        backdoor(1, 16'h2001, 8'hC3);
        issue(1, 1'b0, 1'b0, 16'h2000, 16'h0000, 1'b1, waited);
        issue(1, 1'b0, 1'b0, 16'h2001, 16'h0000, 1'b1, waited);
        chk("b2b_not_ready_cycles", 32'(waited), 32'd3);
        check_trace(1, 1, 1'b0, 1'b0, 16'h2001, 16'h0000);
        sync();

        // Reset in the middle of a W=2 wide write.
        backdoor(2, 16'h5000, 8'h11);
        backdoor(2, 16'h5001, 8'h22);
        issue(2, 1'b1, 1'b1, 16'h5000, 16'hA5C3, 1'b0, waited);
        @(negedge clk);
        chk("midrst_we_before", 32'(mem_we[2]), 32'd1);
        @(posedge clk);
        #2;
        rst_n[2] = 1'b0;
        #1;
        chk("midrst_we_drop", 32'(mem_we[2]), 32'd0);
        chk("midrst_re_drop", 32'(mem_re[2]), 32'd0);
        chk("midrst_ready", 32'(req_ready[2]), 32'd1);
        chk("midrst_rdata", 32'(resp_rdata[2]), 32'd0);
        sync();
        rst_n[2] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("midrst_no_resp_c%0d", c), 32'(resp_valid[2]), 32'd0);
            chk($sformatf("midrst_ready_c%0d", c), 32'(req_ready[2]), 32'd1);
        end
        chk("midrst_lo_written", 32'(mem[2][16'h5000]), 32'hC3);
        chk("midrst_hi_untouched", 32'(mem[2][16'h5001]), 32'h22);
        shadow[2][16'h5000] = 8'hC3;
        last_rd[2]          = '0;
        sync();

        // Random request/wait mix against the SRAM models.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++) backdoor(i, 16'(16'h0100 + j), 8'($urandom));
            backdoor(i, 16'hFFFF, 8'($urandom));
            backdoor(i, 16'h0000, 8'($urandom));
        end
        for (int r = 0; r < 40; r++) begin
            k    = $urandom_range(0, 3);
            wr   = 1'($urandom_range(0, 1));
            wide = 1'($urandom_range(0, 1));
            a    = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'(16'h0100 + $urandom_range(0, 7));
            wd   = 16'($urandom);
            repeat ($urandom_range(0, 2)) sync();
            issue(k, wr, wide, a, wd, 1'b1, waited);
            check_trace(k, k, wr, wide, a, wd);
            sync();
        end
        repeat (3) sync();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++)
                chk($sformatf("final_mem[%0d][%0h]", i, 16'h0100 + j),
                    32'(mem[i][16'(16'h0100 + j)]), 32'(shadow[i][16'(16'h0100 + j)]));
            chk($sformatf("final_mem[%0d][ffff]", i), 32'(mem[i][16'hFFFF]), 32'(shadow[i][16'hFFFF]));
            chk($sformatf("final_mem[%0d][0000]", i), 32'(mem[i][16'h0000]), 32'(shadow[i][16'h0000]));
            chk($sformatf("resp_count[%0d]", i), 32'(resp_cnt[i]), 32'(acc[i]));
        end
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
